tier_cascade_counter: RTL and testbench

//   Parametrised multi-channel synchronous counter bank for the tier-split

---
 rtl/tier_cascade_counter.sv | 98 +++++++++
 tb/tb_tier_cascade_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tier_cascade_counter.sv
// Multi-channel up/down counter bank with optional carry cascade between channels.
// Optional build macro TIER_CO_REG_EN registers the co outputs by one clk1 cycle.

module tcc_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             step,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             term
);
    localparam logic [WIDTH-1:0] ONE = 1;

    always_ff @(posedge clk1) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (step)
            count <= up_dn ? count + ONE : count - ONE;
    end

    // Terminal follows the live direction, so an up_dn change affects this cycle.
    assign term = up_dn ? (&count) : ~(|count);
endmodule

module tier_cascade_counter #(
    parameter int WIDTH   = 4,
    parameter int NCH     = 2,
    parameter int CASCADE = 0
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       up_dn,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic                 inhibit,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       co,
    output logic                 all_term
);
    logic [NCH-1:0] term;
    logic [NCH-1:0] step;
    logic [NCH-1:0] co_int;
    logic           carry;

    // Carry ripples combinationally so a cascaded chain advances in one edge.
    always_comb begin
        step   = '0;
        co_int = '0;
        carry  = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            step[k]   = en[k] & ((CASCADE != 0) ? carry : 1'b1);
            co_int[k] = step[k] & term[k];
            carry     = co_int[k];
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        tcc_lane #(.WIDTH(WIDTH)) u_lane (
            .clk1     (clk1),
            .rst      (rst),
            .step     (step[k]),
            .up_dn    (up_dn[k]),
            .clr      (clr[k]),
            .load     (load[k]),
            .load_val (load_val[k*WIDTH +: WIDTH]),
            .count    (count[k*WIDTH +: WIDTH]),
            .term     (term[k])
        );
    end

    assign all_term = ~inhibit & (&term);

`ifdef TIER_CO_REG_EN
    logic [NCH-1:0] co_q;

    always_ff @(posedge clk1) begin
        if (rst)
            co_q <= '0;
        else
            co_q <= co_int;
    end

    assign co = co_q;
`else
    assign co = co_int;
`endif
endmodule

// File: tb/tb_tier_cascade_counter.sv
// Directed bench for tier_cascade_counter: an independent and a cascaded
// instance share stimulus and are checked against a per-cycle arithmetic model.

module tb_tier_cascade_counter;
    localparam int W = 4;
    localparam int N = 2;
    localparam int M = 16;

    logic         clk1 = 1'b0;
    logic         rst;
    logic [N-1:0] en, up_dn, clr, load;
    logic [7:0]   load_val;
    logic         inhibit;

    logic [7:0]   c0, c1;
    logic [N-1:0] co0, co1;
    logic         at0, at1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk1 = ~clk1;

    tier_cascade_counter #(.WIDTH(W), .NCH(N), .CASCADE(0)) d0 (
        .clk1(clk1), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .inhibit(inhibit), .count(c0), .co(co0), .all_term(at0)
    );

    tier_cascade_counter #(.WIDTH(W), .NCH(N), .CASCADE(1)) d1 (
        .clk1(clk1), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .inhibit(inhibit), .count(c1), .co(co1), .all_term(at1)
    );

    // ---------------- model ----------------
    function automatic bit is_term(input int v, input bit up);
        return up ? (v == M - 1) : (v == 0);
    endfunction

    // A channel moves when its own enable is set and, in a chain, every lower
    // channel is enabled and sitting at its terminal value.
    function automatic logic [N-1:0] m_step(input logic [7:0] st, input bit casc,
                                            input logic [N-1:0] e, input logic [N-1:0] u);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s[k] = e[k];
            if (casc)
                for (int j = 0; j < k; j++)
                    s[k] = s[k] & e[j] & is_term(int'(st[j*W +: W]), u[j]);
        end
        return s;
    endfunction

    function automatic logic [N-1:0] m_co(input logic [7:0] st, input bit casc,
                                          input logic [N-1:0] e, input logic [N-1:0] u);
        logic [N-1:0] s, r;
        s = m_step(st, casc, e, u);
        for (int k = 0; k < N; k++)
            r[k] = s[k] & is_term(int'(st[k*W +: W]), u[k]);
        return r;
    endfunction

    function automatic logic [7:0] m_next(input logic [7:0] st, input bit casc);
        logic [N-1:0] s;
        logic [7:0]   r;
        int           v;
        s = m_step(st, casc, en, up_dn);
        for (int k = 0; k < N; k++) begin
            v = int'(st[k*W +: W]);
            if (rst || clr[k])   v = 0;
            else if (load[k])    v = int'(load_val[k*W +: W]);
            else if (s[k])       v = (v + (up_dn[k] ? 1 : M - 1)) % M;
            r[k*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic bit m_all(input logic [7:0] st);
        bit a;
        a = !inhibit;
        for (int k = 0; k < N; k++)
            a = a & is_term(int'(st[k*W +: W]), up_dn[k]);
        return a;
    endfunction

    logic [7:0]   mc0 = '0, mc1 = '0;
    logic [N-1:0] mq0 = '0, mq1 = '0;

    always @(posedge clk1) begin
        mc0 <= m_next(mc0, 1'b0);
        mc1 <= m_next(mc1, 1'b1);
        mq0 <= rst ? '0 : m_co(mc0, 1'b0, en, up_dn);
        mq1 <= rst ? '0 : m_co(mc1, 1'b1, en, up_dn);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk1) begin
        if (chk_on) begin
            logic [N-1:0] e0, e1;
`ifdef TIER_CO_REG_EN
            e0 = mq0;
            e1 = mq1;
`else
            e0 = m_co(mc0, 1'b0, en, up_dn);
            e1 = m_co(mc1, 1'b1, en, up_dn);
`endif
            chk("model count d0", c0, mc0);
            chk("model count d1", c1, mc1);
            chk("model co d0", {6'd0, co0}, {6'd0, e0});
            chk("model co d1", {6'd0, co1}, {6'd0, e1});
            chk("model all_term d0", {7'd0, at0}, {7'd0, m_all(mc0)});
            chk("model all_term d1", {7'd0, at1}, {7'd0, m_all(mc1)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; en = '0; up_dn = '0; clr = '0; load = '0;
        load_val = '0; inhibit = 1'b0;
        cyc(2);
        chk_on = 1'b1;
        rst = 1'b0; en = 2'b11; up_dn = 2'b11;
        @(negedge clk1);
        chk("reset count d0", c0, 8'h00);
        chk("reset count d1", c1, 8'h00);

        // Count up: independent channels reach F together, chain reads 0x0F.
        cyc(15);
        @(negedge clk1);
        chk("up15 count d0", c0, 8'hFF);
        chk("up15 count d1", c1, 8'h0F);
`ifdef TIER_CO_REG_EN
        chk("up15 co d0", {6'd0, co0}, 8'h00);
`else
        chk("up15 co d0", {6'd0, co0}, 8'h03);
        chk("up15 co d1", {6'd0, co1}, 8'h01);
`endif
        cyc(1);
        @(negedge clk1);
        chk("wrap count d0", c0, 8'h00);
        chk("carry count d1", c1, 8'h10);
`ifdef TIER_CO_REG_EN
        chk("wrap delayed co d0", {6'd0, co0}, 8'h03);
`else
        chk("wrap co d0", {6'd0, co0}, 8'h00);
`endif
        cyc(239);
        @(negedge clk1);
        chk("chain FF count d1", c1, 8'hFF);
        chk("chain FF all_term", {7'd0, at1}, 8'h01);
`ifndef TIER_CO_REG_EN
        chk("chain FF co d1", {6'd0, co1}, 8'h03);
`endif
        #1 inhibit = 1'b1;
        #1 chk("inhibit all_term", {7'd0, at1}, 8'h00);
        inhibit = 1'b0;
        cyc(1);
        @(negedge clk1);
        chk("chain wrap d1", c1, 8'h00);

        // Load beats carry: preload {3,F}, then load channel 1 with A while counting.
        en = 2'b00; load = 2'b11; load_val = 8'h3F;
        cyc(1);
        en = 2'b11; load = 2'b10; load_val = 8'hA5;
        cyc(1);
        load = 2'b00; en = 2'b00;
        @(negedge clk1);
        chk("load beats carry d1", c1, 8'hA0);

        // Count down from 0 on channel 0, then clear at 7.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; en = 2'b01; up_dn = 2'b00;
        @(negedge clk1);
`ifndef TIER_CO_REG_EN
        chk("down co at zero", {6'd0, co0}, 8'h01);
`endif
        cyc(2);
        @(negedge clk1);
        chk("down count E", {4'd0, c0[3:0]}, 8'h0E);
        cyc(7);
        @(negedge clk1);
        chk("down count 7", {4'd0, c0[3:0]}, 8'h07);
        clr = 2'b01;
        cyc(1);
        clr = 2'b00;
        @(negedge clk1);
        chk("clear to 0", {4'd0, c0[3:0]}, 8'h00);

        // Cascaded down-count borrow: 00 -> FF in one edge.
        en = 2'b11;
        cyc(1);
        @(negedge clk1);
        chk("chain borrow d1", c1, 8'hFF);

        // Mid-run reset.
        up_dn = 2'b11;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk1);
        chk("midrun rst d0", c0, 8'h00);
        chk("midrun rst d1", c1, 8'h00);
        chk("midrun rst co d1", {6'd0, co1}, 8'h00);

        // Mixed patterns, checked only against the model.
        for (int i = 0; i < 60; i++) begin
            en       = 2'(i % 4 == 3 ? 1 : 3);
            up_dn    = 2'((i / 7) % 4);
            clr      = (i % 17 == 5) ? 2'b10 : 2'b00;
            load     = (i % 13 == 9) ? 2'b01 : 2'b00;
            load_val = 8'(i * 37);
            inhibit  = (i % 11 == 4);
            cyc(1);
        end
        clr = '0; load = '0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
